assoc_cache: RTL and testbench

Parametrised set-associative, write-through cache placed between a requesting client and a slower backing memory. It generalises the earlier fully-associative single-word store with the following additions:
- configurable ways and sets;
- FIFO replacement per set that prefers invalid ways;
- valid/ready request handshaking and a memory-side miss/write-through interface;
- a single-cycle flush;
- hit/miss statistics.

Each line holds one DATA_WIDTH word.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/assoc_cache_if.sv | 36 +++
 rtl/cache_victim_sel.sv | 24 ++
 rtl/assoc_cache.sv | 176 +++++++++++++++++
 tb/tb_assoc_cache.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

  // Width of the set index for a given number of sets.
  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  // Width of the tag left over once the index is taken from the address.
  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
    return addr_w - $clog2(sets);
  endfunction

  // Width of a way pointer; a direct-mapped cache still carries one bit.
  function automatic int unsigned ptr_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// Client request/response and backing-memory signals of the cache.
interface assoc_cache_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_hit;

  logic                  mem_req_valid;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Cache side: serves client requests and masters the memory port.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req_valid, mem_req_write, mem_addr, mem_wdata
  );

  // Environment side: the requesting client together with the backing memory.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req_valid, mem_req_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_victim_sel.sv
// Victim way selection for one set: lowest invalid way, else the FIFO pointer.
module cache_victim_sel #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [WAYS-1:0]  valid,
  input  logic [PTR_W-1:0] fifo_ptr,
  output logic [PTR_W-1:0] victim,
  output logic             advance
);

  // Scan upward so the first invalid way found is the lowest one.
  always_comb begin
    victim  = fifo_ptr;
    advance = 1'b1;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (advance && !valid[i]) begin
        victim  = PTR_W'(i);
        advance = 1'b0;
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative write-through cache, one word per line, FIFO replacement.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  assoc_cache_if.slave         bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int unsigned INDEX_W = index_w(SETS);
  localparam int unsigned TAG_W   = tag_w(ADDR_WIDTH, SETS);
  localparam int unsigned PTR_W   = ptr_w(WAYS);

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  hit_q;
  logic [PTR_W-1:0]      hit_way_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rhit_q;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS];
  logic [PTR_W-1:0]      fifo_q  [SETS];

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               lk_hit;
  logic [PTR_W-1:0]   lk_way;
  logic [PTR_W-1:0]   victim;
  logic               advance;
  logic [PTR_W-1:0]   next_ptr;

  logic accept, do_flush, ack_rd, ack_wr, alloc, update;

  assign idx = addr_q[INDEX_W-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:INDEX_W];

  assign accept   = (state_q == IDLE) && bus.req_valid && !flush;
  assign do_flush = (state_q == IDLE) && flush;
  assign ack_rd   = (state_q == MEM_RD) && bus.mem_ack;
  assign ack_wr   = (state_q == MEM_WR) && bus.mem_ack;
  assign alloc    = ack_rd || (ack_wr && !hit_q);
  assign update   = ack_wr && hit_q;

  assign next_ptr = (fifo_q[idx] == PTR_W'(WAYS - 1)) ? '0 : fifo_q[idx] + 1'b1;

  // Tag compare across all valid ways of the addressed set.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!lk_hit && valid_q[idx][i] && (tag_q[idx][i] == tag)) begin
        lk_hit = 1'b1;
        lk_way = PTR_W'(i);
      end
    end
  end

  cache_victim_sel #(
    .WAYS  (WAYS),
    .PTR_W (PTR_W)
  ) u_victim (
    .valid    (valid_q[idx]),
    .fifo_ptr (fifo_q[idx]),
    .victim   (victim),
    .advance  (advance)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = write_q ? MEM_WR : (lk_hit ? RESP : MEM_RD);
      MEM_RD:  if (bus.mem_ack) state_d = RESP;
      MEM_WR:  if (bus.mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch, lookup result and response data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      rdata_q   <= '0;
      rhit_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == LOOKUP) begin
        hit_q     <= lk_hit;
        hit_way_q <= lk_way;
        rhit_q    <= lk_hit;
        if (lk_hit) rdata_q <= data_q[idx][lk_way];
      end
      if (ack_rd) rdata_q <= bus.mem_rdata;
      if (ack_wr) rdata_q <= wdata_q;
    end
  end

  // Valid bits and per-set FIFO pointers; flush leaves the pointers alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        fifo_q[s]  <= '0;
      end
    end else if (do_flush) begin
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (alloc) begin
      valid_q[idx][victim] <= 1'b1;
      if (advance) fifo_q[idx] <= next_ptr;
    end
  end

  // Tag and data storage; contents are qualified by the valid bits so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= ack_rd ? bus.mem_rdata : wdata_q;
    end else if (update) begin
      data_q[idx][hit_way_q] <= wdata_q;
    end
  end

  // Saturating hit/miss statistics, counted once per request at lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == LOOKUP) begin
      if (lk_hit) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 1'b1;
      end
    end
  end

  assign bus.req_ready     = (state_q == IDLE) && !flush;
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_hit      = rhit_q;
  assign bus.mem_req_valid = (state_q == MEM_RD) || (state_q == MEM_WR);
  assign bus.mem_req_write = (state_q == MEM_WR);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache: reference cache model plus a backing-memory responder.
module tb_assoc_cache;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  assoc_cache #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAYS       (WAYS),
    .SETS       (SETS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          hit;
    logic          chk_lat;
    int            acc;
  } resp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } memx_t;

  resp_t resp_q[$];
  memx_t memx_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int n_resp = 0;
  int mem_delay = -1;

  // Backing memory as seen by the responder, and the architectural memory image of the model.
  logic [DW-1:0] mem_arr [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];

  // Reference cache: only which tags are resident per set, plus FIFO order.
  bit m_valid [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_fifo  [SETS];
  int m_hits, m_misses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_fifo[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endfunction

  function automatic bit model_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int s = int'(a) % SETS;
    int t = int'(a) / SETS;
    int slot = -1;
    bit hit = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_valid[s][w] && m_tag[s][w] == t) hit = 1'b1;
    if (hit) m_hits++;
    else     m_misses++;
    if (wr) ref_mem[a] = d;
    if (!hit) begin
      for (int w = 0; w < WAYS; w++)
        if (slot < 0 && !m_valid[s][w]) slot = w;
      if (slot < 0) begin
        slot = m_fifo[s];
        m_fifo[s] = (m_fifo[s] + 1) % WAYS;
      end
      m_valid[s][slot] = 1'b1;
      m_tag[s][slot] = t;
    end
    return hit;
  endfunction

  // Response monitor: pops one expectation per response pulse.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        n_resp++;
        check("resp_expected", 32'(resp_q.size() != 0), 1);
        if (resp_q.size() != 0) begin
          e = resp_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_hit", bus.resp_hit, e.hit);
          if (e.chk_lat) check("read_hit_latency", cyc - e.acc, 1);
        end
      end
    end
  end

  // Backing memory: checks each new request, its stability, and acks after a delay.
  initial begin
    bit    busy = 1'b0;
    int    wc = 0;
    memx_t cap;
    memx_t ex;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req_valid !== 1'b1) begin
        busy = 1'b0;
        continue;
      end
      if (!busy) begin
        busy = 1'b1;
        cap.wr = bus.mem_req_write;
        cap.addr = bus.mem_addr;
        cap.wdata = bus.mem_wdata;
        check("mem_req_expected", 32'(memx_q.size() != 0), 1);
        if (memx_q.size() != 0) begin
          ex = memx_q.pop_front();
          check("mem_req_write", cap.wr, ex.wr);
          check("mem_addr", cap.addr, ex.addr);
          if (ex.wr) check("mem_wdata", cap.wdata, ex.wdata);
        end
        wc = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end else begin
        check("mem_stable", {bus.mem_req_write, bus.mem_addr, bus.mem_wdata},
              {cap.wr, cap.addr, cap.wdata});
      end
      if (wc == 0) begin
        bus.mem_ack = 1'b1;
        if (!cap.wr) bus.mem_rdata = mem_arr[cap.addr];
        else         mem_arr[cap.addr] = cap.wdata;
        busy = 1'b0;
      end else begin
        wc--;
      end
    end
  end

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_flush);
    int    n0;
    int    k;
    bit    hit;
    resp_t e;
    memx_t m;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    if (with_flush) begin
      flush = 1'b1;
      #1;
      check("ready_low_during_flush", bus.req_ready, 0);
      @(posedge clk);
      model_flush();
      @(negedge clk);
      flush = 1'b0;
    end
    #1;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("req_ready", bus.req_ready, 1);
    if (bus.req_ready !== 1'b1) begin
      bus.req_valid = 1'b0;
      return;
    end
    n0 = n_resp;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    hit = model_access(wr, a, d);
    e.rdata = wr ? d : ref_mem[a];
    e.hit = hit;
    e.chk_lat = hit && !wr;
    e.acc = cyc;
    resp_q.push_back(e);
    if (wr || !hit) begin
      m.wr = wr;
      m.addr = a;
      m.wdata = d;
      memx_q.push_back(m);
    end
    k = 0;
    while (n_resp == n0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("resp_arrived", 32'(n_resp != n0), 1);
    #1;
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("ready_low_during_flush", bus.req_ready, 0);
    @(posedge clk);
    model_flush();
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("hit_count_after_flush", hit_count, m_hits);
    check("miss_count_after_flush", miss_count, m_misses);
  endtask

  task automatic reset_mid_read(input logic [AW-1:0] a);
    memx_t m;
    int    k;
    int    n0;
    mem_delay = 20;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = '0;
    #1;
    check("req_ready_before_rst", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    m.wr = 1'b0;
    m.addr = a;
    m.wdata = '0;
    memx_q.push_back(m);
    k = 0;
    while (bus.mem_req_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reached_mem_rd", bus.mem_req_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mem_req_low_after_rst", bus.mem_req_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n0 = n_resp;
    repeat (8) @(negedge clk);
    check("no_resp_after_rst", n_resp, n0);
    check("hit_count_after_rst", hit_count, 0);
    check("miss_count_after_rst", miss_count, 0);
    mem_delay = -1;
    do_req(1'b0, a, '0, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    mem_arr[13'h0010] = 8'hA5;
    ref_mem[13'h0010] = 8'hA5;
    model_reset();

    rst = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_hit", bus.resp_hit, 0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_req_write", bus.mem_req_write, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);

    // Miss with a 3-cycle memory, then the same address hits.
    mem_delay = 3;
    do_req(1'b0, 13'h0010, '0, 1'b0);
    check("first_miss_count", miss_count, 1);
    do_req(1'b0, 13'h0010, '0, 1'b0);
    check("first_hit_count", hit_count, 1);
    mem_delay = -1;

    // Fill set 0 and walk the FIFO victim order.
    do_req(1'b0, 13'h0110, '0, 1'b0);
    do_req(1'b0, 13'h0210, '0, 1'b0);
    do_req(1'b0, 13'h0310, '0, 1'b0);
    do_req(1'b0, 13'h0410, '0, 1'b0);
    do_req(1'b0, 13'h0010, '0, 1'b0);
    do_req(1'b0, 13'h0110, '0, 1'b0);
    do_req(1'b0, 13'h0410, '0, 1'b0);

    // Write-through, then read back as a hit.
    do_req(1'b1, 13'h0020, 8'h3C, 1'b0);
    do_req(1'b0, 13'h0020, '0, 1'b0);

    // Flush invalidates resident lines.
    do_req(1'b0, 13'h0031, '0, 1'b0);
    do_req(1'b0, 13'h0042, '0, 1'b0);
    do_req(1'b0, 13'h0031, '0, 1'b0);
    do_flush();
    do_req(1'b0, 13'h0031, '0, 1'b0);
    do_req(1'b0, 13'h0020, '0, 1'b0);

    // Flush and request together: request waits one cycle.
    do_req(1'b0, 13'h0031, '0, 1'b1);

    // Reset while the memory read is outstanding.
    reset_mid_read(13'h0777);

    // Random traffic over a few conflicting tags per set.
    for (int n = 0; n < 400; n++) begin
      a = AW'($urandom_range(0, 5) * SETS + $urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) do_flush();
      do_req($urandom_range(0, 99) < 30, a, DW'($urandom), $urandom_range(0, 99) < 3);
    end

    repeat (10) @(negedge clk);
    check("resp_queue_drained", resp_q.size(), 0);
    check("mem_queue_drained", memx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
